// File: rtl/alu_scheduler_if.sv
// Bundle of request, ALU and response signals around the ALU scheduler.
// The slave modport is the scheduler's view; the master modport is the view of the front ends and the ALU.
interface alu_scheduler_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic [2:0]  req0_cmd;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic [2:0]  req1_cmd;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_cmd;
  logic [14:0] alu_res;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [14:0] resp_res;
  logic        resp_err;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cmd,
    input  req1_valid, req1_a, req1_b, req1_cmd,
    input  alu_res, resp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_cmd,
    output resp_valid, resp_id, resp_res, resp_err, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cmd,
    output req1_valid, req1_a, req1_b, req1_cmd,
    output alu_res, resp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_cmd,
    input  resp_valid, resp_id, resp_res, resp_err, busy
  );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin sharing of one ALU between two requesters.
// Each operation is held on the ALU for LATENCY cycles, and its result is returned with the requester ID.
//
// state | meaning
// IDLE  | waiting for a request; the grant goes to a requester
// EXEC  | operands held on the ALU; counting down to capture
// RESP  | response valid and held until resp_ready
module alu_scheduler #(
  parameter int unsigned LATENCY = 2
) (
  input logic            clk,
  input logic            reset,
  alu_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q;
  logic        last_id_q;
  logic [3:0]  cnt_q;
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic [2:0]  alu_cmd_q;
  logic [14:0] resp_res_q;
  logic        resp_id_q;
  logic        resp_err_q;
  logic        resp_valid_q;
  logic        busy_q;

  logic        grant_id;
  logic        accept;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic [2:0]  sel_cmd;
  logic        reject;

  always_comb begin
    grant_id = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_id = ~last_id_q;
    accept  = !reset && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    sel_a   = grant_id ? bus.req1_a   : bus.req0_a;
    sel_b   = grant_id ? bus.req1_b   : bus.req0_b;
    sel_cmd = grant_id ? bus.req1_cmd : bus.req0_cmd;
    // A divisor of zero is judged on the magnitude alone; bit 0 is the sign.
    reject  = (sel_cmd == 3'd7) ||
              (((sel_cmd == 3'd5) || (sel_cmd == 3'd6)) && (sel_b[15:1] == 15'd0));
  end

  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept &&  grant_id;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cmd    = alu_cmd_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_res   = resp_res_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_id_q    <= 1'b1;
      cnt_q        <= 4'd0;
      alu_a_q      <= 16'd0;
      alu_b_q      <= 16'd0;
      alu_cmd_q    <= 3'd0;
      resp_res_q   <= 15'd0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            last_id_q <= grant_id;
            resp_id_q <= grant_id;
            busy_q    <= 1'b1;
            if (reject) begin
              resp_err_q   <= 1'b1;
              resp_res_q   <= 15'd0;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              alu_a_q   <= sel_a;
              alu_b_q   <= sel_b;
              alu_cmd_q <= sel_cmd;
              cnt_q     <= 4'(LATENCY - 1);
              state_q   <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            resp_res_q   <= bus.alu_res;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: one instance uses LATENCY=2 and a second uses LATENCY=5.
// Each instance is attached to a behavioural magnitude ALU.
module tb_alu_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_scheduler_if if0 ();
  alu_scheduler_if if5 ();

  alu_scheduler #(.LATENCY(2)) u_dut  (.clk(clk), .reset(reset), .bus(if0.slave));
  alu_scheduler #(.LATENCY(5)) u_dut5 (.clk(clk), .reset(reset), .bus(if5.slave));

  // Operands carry the magnitude in [15:1] and the sign in bit 0.
  function automatic logic [14:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] cmd);
    logic [14:0] ma, mb;
    logic [29:0] p;
    ma = a[15:1];
    mb = b[15:1];
    p  = ma * mb;
    case (cmd)
      3'd0: alu_f = ma + mb;
      3'd1: alu_f = ma - mb;
      3'd2: alu_f = ma & mb;
      3'd3: alu_f = p[14:0];
      3'd4: alu_f = p[29:15];
      3'd5: alu_f = (mb != 0) ? ma / mb : 15'd0;
      3'd6: alu_f = (mb != 0) ? ma % mb : 15'd0;
      default: alu_f = 15'd0;
    endcase
  endfunction

  assign if0.alu_res = alu_f(if0.alu_a, if0.alu_b, if0.alu_cmd);
  assign if5.alu_res = alu_f(if5.alu_a, if5.alu_b, if5.alu_cmd);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if0.req0_valid = 1'b1; if0.req0_a = 16'h0006; if0.req0_b = 16'h0004; if0.req0_cmd = 3'd0;
    if0.req1_valid = 1'b1; if0.req1_a = 16'h000A; if0.req1_b = 16'h0004; if0.req1_cmd = 3'd1;
    if0.resp_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({if0.req0_ready, if0.req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b exp 00", {if0.req0_ready, if0.req1_ready});
    end
    checks++;
    if ({if0.alu_a, if0.alu_b, if0.alu_cmd} !== 35'd0) begin
      errors++; $display("FAIL reset_alu got %h %h %h exp 0", if0.alu_a, if0.alu_b, if0.alu_cmd);
    end
    checks++;
    if ({if0.resp_valid, if0.resp_id, if0.resp_err, if0.resp_res, if0.busy} !== 19'd0) begin
      errors++; $display("FAIL reset_resp got v%b id%b e%b r%h busy%b exp all 0",
                         if0.resp_valid, if0.resp_id, if0.resp_err, if0.resp_res, if0.busy);
    end
    reset = 1'b0;
    if0.req0_valid = 1'b0; if0.req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_add();
    if0.req0_valid = 1'b1; if0.req0_a = 16'h0006; if0.req0_b = 16'h0004; if0.req0_cmd = 3'd0;
    #1;
    checks++;
    if ({if0.req0_ready, if0.req1_ready} !== 2'b10) begin
      errors++; $display("FAIL add_ready got %b exp 10", {if0.req0_ready, if0.req1_ready});
    end
    tick();
    if0.req0_valid = 1'b0; if0.req0_a = 16'hFFFF; if0.req0_cmd = 3'd7;
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if ({if0.alu_a, if0.alu_b, if0.alu_cmd, if0.resp_valid, if0.busy} !== {16'h0006, 16'h0004, 3'd0, 1'b0, 1'b1}) begin
        errors++; $display("FAIL add_exec%0d got a%h b%h c%0d v%b busy%b exp a0006 b0004 c0 v0 busy1",
                           i, if0.alu_a, if0.alu_b, if0.alu_cmd, if0.resp_valid, if0.busy);
      end
      tick();
    end
    checks++;
    if ({if0.resp_valid, if0.resp_res, if0.resp_id, if0.resp_err} !== {1'b1, 15'd5, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_resp got v%b r%0d id%b e%b exp v1 r5 id0 e0",
                         if0.resp_valid, if0.resp_res, if0.resp_id, if0.resp_err);
    end
    tick();
    checks++;
    if ({if0.busy, if0.resp_valid} !== 2'b00) begin
      errors++; $display("FAIL add_idle got busy%b v%b exp 0 0", if0.busy, if0.resp_valid);
    end
  endtask

  task automatic test_tie();
    int cyc, last_acc, k;
    logic exp_id;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    if0.resp_ready = 1'b1;
    if0.req0_valid = 1'b1; if0.req0_a = 16'h0006; if0.req0_b = 16'h0004; if0.req0_cmd = 3'd3;
    if0.req1_valid = 1'b1; if0.req1_a = 16'h000A; if0.req1_b = 16'h0004; if0.req1_cmd = 3'd1;
    #1;
    cyc = 0; last_acc = 0; exp_id = 1'b0;
    for (int op = 0; op < 8; op++) begin
      k = 0;
      while (!(if0.req0_ready || if0.req1_ready) && k < 20) begin tick(); cyc++; k++; end
      checks++;
      if ({if0.req1_ready, if0.req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL tie_grant op%0d got r1r0=%b exp id %b", op,
                           {if0.req1_ready, if0.req0_ready}, exp_id);
      end
      if (op > 0) begin
        checks++;
        if (cyc - last_acc !== 4) begin
          errors++; $display("FAIL tie_spacing op%0d got %0d exp 4", op, cyc - last_acc);
        end
      end
      last_acc = cyc;
      tick(); cyc++;
      k = 0;
      while (!if0.resp_valid && k < 20) begin tick(); cyc++; k++; end
      checks++;
      if ({if0.resp_valid, if0.resp_id, if0.resp_err, if0.resp_res} !==
          {1'b1, exp_id, 1'b0, (exp_id ? 15'd3 : 15'd6)}) begin
        errors++; $display("FAIL tie_resp op%0d got v%b id%b e%b r%0d exp id%b r%0d", op,
                           if0.resp_valid, if0.resp_id, if0.resp_err, if0.resp_res,
                           exp_id, exp_id ? 3 : 6);
      end
      exp_id = ~exp_id;
      tick(); cyc++;
    end
    if0.req0_valid = 1'b0; if0.req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_div0();
    for (int r = 0; r < 2; r++) begin
      if0.req1_valid = 1'b1; if0.req1_a = 16'h0008;
      if0.req1_b   = (r == 0) ? 16'h0001 : 16'h0004;
      if0.req1_cmd = (r == 0) ? 3'd6 : 3'd7;
      #1;
      checks++;
      if (if0.req1_ready !== 1'b1) begin
        errors++; $display("FAIL rej%0d_ready got %b exp 1", r, if0.req1_ready);
      end
      tick();
      if0.req1_valid = 1'b0;
      checks++;
      if ({if0.resp_valid, if0.resp_err, if0.resp_res, if0.resp_id} !== {1'b1, 1'b1, 15'd0, 1'b1}) begin
        errors++; $display("FAIL rej%0d_resp got v%b e%b r%0d id%b exp v1 e1 r0 id1", r,
                           if0.resp_valid, if0.resp_err, if0.resp_res, if0.resp_id);
      end
      checks++;
      if ({if0.alu_cmd, if0.alu_a, if0.alu_b} !== {3'd1, 16'h000A, 16'h0004}) begin
        errors++; $display("FAIL rej%0d_alu got c%0d a%h b%h exp c1 a000a b0004", r,
                           if0.alu_cmd, if0.alu_a, if0.alu_b);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    if0.resp_ready = 1'b0;
    if0.req0_valid = 1'b1; if0.req0_a = 16'h0010; if0.req0_b = 16'h0002; if0.req0_cmd = 3'd0;
    tick();
    if0.req1_valid = 1'b1; if0.req1_cmd = 3'd0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({if0.resp_valid, if0.resp_res, if0.resp_id, if0.resp_err, if0.busy,
           if0.req0_ready, if0.req1_ready} !== {1'b1, 15'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d got v%b r%0d id%b e%b busy%b rdy%b%b exp v1 r9 id0 e0 busy1 rdy00",
                           i, if0.resp_valid, if0.resp_res, if0.resp_id, if0.resp_err, if0.busy,
                           if0.req0_ready, if0.req1_ready);
      end
      tick();
    end
    if0.resp_ready = 1'b1; if0.req0_valid = 1'b0; if0.req1_valid = 1'b0;
    tick();
    checks++;
    if ({if0.busy, if0.resp_valid} !== 2'b00) begin
      errors++; $display("FAIL bp_release got busy%b v%b exp 0 0", if0.busy, if0.resp_valid);
    end
  endtask

  task automatic test_reset_mid_exec();
    int k;
    logic seen;
    if0.resp_ready = 1'b1;
    if0.req0_valid = 1'b1; if0.req0_a = 16'h00FE; if0.req0_b = 16'h000E; if0.req0_cmd = 3'd2;
    tick();
    if0.req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({if0.alu_a, if0.alu_b, if0.alu_cmd, if0.resp_valid, if0.resp_id, if0.resp_err,
         if0.resp_res, if0.busy} !== 54'd0) begin
      errors++; $display("FAIL rst_exec got a%h b%h c%0d v%b id%b e%b r%0d busy%b exp all 0",
                         if0.alu_a, if0.alu_b, if0.alu_cmd, if0.resp_valid, if0.resp_id,
                         if0.resp_err, if0.resp_res, if0.busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); seen = seen | if0.resp_valid; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_no_resp got %b exp 0", seen);
    end
    if0.req0_valid = 1'b1; if0.req0_a = 16'h0014; if0.req0_b = 16'h0006; if0.req0_cmd = 3'd1;
    #1;
    checks++;
    if (if0.req0_ready !== 1'b1) begin
      errors++; $display("FAIL rst_next_ready got %b exp 1", if0.req0_ready);
    end
    tick();
    if0.req0_valid = 1'b0;
    k = 0;
    while (!if0.resp_valid && k < 20) begin tick(); k++; end
    checks++;
    if ({if0.resp_valid, if0.resp_res, if0.resp_id, if0.resp_err} !== {1'b1, 15'd7, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_next_resp got v%b r%0d id%b e%b exp v1 r7 id0 e0",
                         if0.resp_valid, if0.resp_res, if0.resp_id, if0.resp_err);
    end
    tick();
  endtask

  task automatic test_latency5();
    if5.resp_ready = 1'b1;
    if5.req0_valid = 1'b1; if5.req0_a = 16'h0006; if5.req0_b = 16'h0004; if5.req0_cmd = 3'd0;
    #1;
    checks++;
    if (if5.req0_ready !== 1'b1) begin
      errors++; $display("FAIL l5_ready got %b exp 1", if5.req0_ready);
    end
    tick();
    if5.req0_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if ({if5.alu_a, if5.alu_b, if5.alu_cmd, if5.resp_valid} !== {16'h0006, 16'h0004, 3'd0, 1'b0}) begin
        errors++; $display("FAIL l5_exec%0d got a%h b%h c%0d v%b exp a0006 b0004 c0 v0",
                           i, if5.alu_a, if5.alu_b, if5.alu_cmd, if5.resp_valid);
      end
      tick();
    end
    checks++;
    if ({if5.resp_valid, if5.resp_res, if5.resp_id, if5.resp_err} !== {1'b1, 15'd5, 1'b0, 1'b0}) begin
      errors++; $display("FAIL l5_resp got v%b r%0d id%b e%b exp v1 r5 id0 e0",
                         if5.resp_valid, if5.resp_res, if5.resp_id, if5.resp_err);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    if5.req0_valid = 1'b0; if5.req0_a = 16'd0; if5.req0_b = 16'd0; if5.req0_cmd = 3'd0;
    if5.req1_valid = 1'b0; if5.req1_a = 16'd0; if5.req1_b = 16'd0; if5.req1_cmd = 3'd0;
    if5.resp_ready = 1'b1;
    test_reset();
    test_add();
    test_tie();
    test_div0();
    test_backpressure();
    test_reset_mid_exec();
    test_latency5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Shares the single 16-bit behavioural ALU between two requesters. Arbitrates round-robin, latches one operation, drives the ALU operand and command inputs stable for a fixed latency, then captures `res` and returns it on a response channel tagged with the requester ID. Illegal commands and divide-by-zero are rejected without touching the ALU. Sits between the two operand-producing front ends and the ALU instance.

## Interface
- `LATENCY`, 2: cycles operands are held on the ALU before `alu_res` is captured; legal range 1..15.
- `clk` in 1: rising-edge clock shared with the ALU.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 accepted this cycle when `req0_valid` is also high.
- `req0_a` in 16: operand A, 1.15 sign-magnitude as consumed by the ALU.
- `req0_b` in 16: operand B, same format.
- `req0_cmd` in 3: 0 ADD, 1 SUB, 2 AND, 3 MP0, 4 MP1, 5 DV0, 6 DV1, 7 illegal.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cmd`: same meanings for requester 1.
- `alu_a` out 16: operand A to the ALU.
- `alu_b` out 16: operand B to the ALU.
- `alu_cmd` out 3: command to the ALU.
- `alu_res` in 15: ALU result.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer takes the response.
- `resp_id` out 1: requester that issued the operation.
- `resp_res` out 15: captured result; 0 when `resp_err` is high.
- `resp_err` out 1: operation rejected.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE
  - `reqN_ready = (state==IDLE) && grant==N`. This is combinational from the registered state and the valids.
  - Grant rule: if only one valid, grant it. If both are valid, grant the requester not in `last_id`.
  - `last_id` resets to 1, so req0 wins the first tie.
- Accept (valid & ready)
  - Latch a, b, cmd and id, and set `last_id`.
  - Reject when cmd==7, or when cmd∈{5,6} and b[15:1]==0.
  - On reject: go to RESP with `resp_err`=1 and `resp_res`=0. `alu_*` are not updated.
  - Otherwise: load `alu_a`/`alu_b`/`alu_cmd` from the request, load counter = LATENCY-1, and go to EXEC.
- EXEC
  - `alu_*` held constant.
  - Counter decrements each cycle.
  - On the cycle counter==0: capture `alu_res` into `resp_res`, `resp_err`=0, go to RESP.
- RESP
  - `resp_valid`=1, and `resp_id`/`resp_res`/`resp_err` stay stable until `resp_valid & resp_ready`.
  - After the handshake, go to IDLE and clear `resp_valid` on the next cycle.
- `alu_*` keep their last values in IDLE and RESP; they are not zeroed.
- No result arithmetic: `resp_res` is the ALU output bit-for-bit.
- Reset (any state, including mid-EXEC or RESP)
  - Next cycle: state IDLE; `alu_a`, `alu_b`, `alu_cmd`, `resp_res`, `resp_id`, `resp_err`, `resp_valid`, `busy` all 0.
  - `last_id`=1, counter=0. Any in-flight result is discarded.
  - `reqN_ready` is low while `reset` is high.

## Timing
- Accept at edge T (handshake in cycle T).
- `alu_*` are valid from cycle T+1 through T+LATENCY.
- Capture at the end of cycle T+LATENCY.
- `resp_valid` is high from cycle T+LATENCY+1.
- Reject path: `resp_valid` is high from cycle T+1.
- With `resp_ready` held high, the response handshake occurs in the first RESP cycle. IDLE follows one cycle later, so the earliest next accept is at T+LATENCY+2.
- Throughput: one operation per LATENCY+2 cycles.
- A request's fields may change once its ready has been sampled high. The unit never re-reads them.
- A requester holding valid while not granted is not dropped. Under continuous contention, grants alternate 0,1,0,1.

## Test plan
- **ADD, LATENCY=2, real ALU attached:** req0 cmd=0, A=16'h0006, B=16'h0004 accepted at T -> `alu_cmd`=0 during T+1..T+2; `resp_valid` at T+3 with `resp_res`=15'd5, `resp_id`=0, `resp_err`=0.
- **Tie after reset:** both valid, req0 MP0 3×2 (A=16'h0006, B=16'h0004), req1 SUB (A=16'h000A, B=16'h0004) -> req0 served first with `resp_res`=6, then req1 with `resp_res`=3. Grants alternate over 4 back-to-back pairs.
- **Divide-by-zero:** req1 cmd=6, B=16'h0001 -> `resp_valid` at T+1, `resp_err`=1, `resp_res`=0, `alu_cmd` unchanged. Repeat with cmd=7 for the same result.
- **Backpressure:** `resp_ready` low for 5 cycles after `resp_valid` -> `resp_*` stable; `req0_ready` and `req1_ready` low; `busy`=1. Raise `resp_ready` -> `busy`=0 on the next cycle.
- **Reset mid-EXEC:** assert `reset` one cycle at T+1 -> all outputs 0 the next cycle; no `resp_valid` for the aborted operation; a subsequent req0 operation completes normally.
- **LATENCY=5 build:** `alu_*` stable for exactly 5 cycles; `resp_valid` first high at T+6.
